diff_detect_sequencer: RTL and testbench

Phase 0 sequencer that drives correlation_calc through repeated measurement trials on the 20-pin data pair. It classifies each trial as differential, single-ended, no-signal or unusable, and majority-votes the trials into one interface verdict: ESDI differential vs ST-506 single-ended. It runs in the 300 MHz HDD domain, between the Phase 0 detection controller (start/abort/result) and one correlation_calc instance (enable/clear/results).

---
 rtl/diff_detect_sequencer.sv | 209 ++++++++++++++++++++
 tb/tb_diff_detect_sequencer.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/diff_detect_sequencer.sv
// Phase 0 interface detector: runs correlation_calc through repeated trials on the
// 20-pin data pair and majority-votes them into differential vs single-ended.
module diff_detect_sequencer #(
  parameter int unsigned SETTLE_CYCLES  = 16,
  parameter int unsigned MIN_EDGES      = 256,
  parameter int unsigned TIMEOUT_CYCLES = 3000000,
  parameter int unsigned NUM_TRIALS     = 3,
  parameter int unsigned DIFF_THRESH    = 200,
  parameter int unsigned SE_THRESH      = 50,
  parameter int unsigned MIN_QUALITY    = 128
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  output logic        calc_enable,
  output logic        calc_clear,
  input  logic [7:0]  calc_correlation,
  input  logic [15:0] calc_edge_count,
  input  logic [7:0]  calc_quality,
  output logic        busy,
  output logic        done,
  output logic [1:0]  result,
  output logic [2:0]  trial_idx,
  output logic [2:0]  diff_votes,
  output logic [2:0]  se_votes,
  output logic [7:0]  last_correlation
);

  localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [SET_W-1:0] SET_LOAD = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [15:0]      EDGE_MIN = 16'(MIN_EDGES);
  localparam logic [7:0]       DIFF_T   = 8'(DIFF_THRESH);
  localparam logic [7:0]       SE_T     = 8'(SE_THRESH);
  localparam logic [7:0]       QUAL_MIN = 8'(MIN_QUALITY);
  localparam logic [3:0]       NT4      = 4'(NUM_TRIALS);
  localparam logic [2:0]       LAST_IDX = 3'(NUM_TRIALS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_SETTLE, S_MEASURE, S_SAMPLE, S_DECIDE, S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [SET_W-1:0] settle_cnt_q, settle_cnt_d;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             sample_ph_q, sample_ph_d;
  logic [2:0]       trial_idx_q, trial_idx_d;
  logic [2:0]       diff_votes_q, diff_votes_d;
  logic [2:0]       se_votes_q, se_votes_d;
  logic [2:0]       nosig_q, nosig_d;
  logic [7:0]       last_corr_q, last_corr_d;
  logic [1:0]       result_q, result_d;
  logic             calc_enable_q, calc_enable_d;
  logic             calc_clear_q, calc_clear_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic       meas_hit, meas_tmo, sample_fire, qual_ok;
  logic       diff_hit, se_hit, trial_end, finish_run;
  logic [2:0] diff_new, se_new, nosig_new;

  function automatic logic [2:0] sat_inc(input logic [2:0] c, input logic en);
    if (en && (c != 3'd7)) return c + 3'd1;
    return c;
  endfunction

  // Twice the count, kept at 4 bits, against the trial total.
  function automatic logic majority(input logic [2:0] c);
    return {c, 1'b0} > NT4;
  endfunction

  // Trial classification and the trial-end decision, shared by FSM and datapath.
  always_comb begin
    meas_hit    = (state_q == S_MEASURE) && (calc_edge_count >= EDGE_MIN);
    meas_tmo    = (state_q == S_MEASURE) && !meas_hit && (tmo_cnt_q == '0);
    sample_fire = (state_q == S_SAMPLE) && sample_ph_q;
    qual_ok     = calc_quality >= QUAL_MIN;
    diff_hit    = sample_fire && qual_ok && (calc_correlation >= DIFF_T);
    se_hit      = sample_fire && qual_ok && !diff_hit && (calc_correlation <= SE_T);
    diff_new    = sat_inc(diff_votes_q, diff_hit);
    se_new      = sat_inc(se_votes_q, se_hit);
    nosig_new   = sat_inc(nosig_q, meas_tmo);
    trial_end   = meas_tmo || sample_fire;
    finish_run  = majority(diff_new) || majority(se_new) || majority(nosig_new) ||
                  (trial_idx_q == LAST_IDX);
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:    if (start && !abort) state_d = S_CLEAR;
        S_CLEAR:   state_d = S_SETTLE;
        S_SETTLE:  if (settle_cnt_q == '0) state_d = S_MEASURE;
        S_MEASURE: begin
          if (meas_hit)      state_d = S_SAMPLE;
          else if (meas_tmo) state_d = finish_run ? S_DECIDE : S_CLEAR;
        end
        S_SAMPLE:  if (sample_fire) state_d = finish_run ? S_DECIDE : S_CLEAR;
        S_DECIDE:  state_d = S_DONE;
        S_DONE:    state_d = S_IDLE;
        default:   state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    settle_cnt_d = settle_cnt_q;
    tmo_cnt_d    = tmo_cnt_q;
    sample_ph_d  = 1'b0;
    trial_idx_d  = trial_idx_q;
    diff_votes_d = diff_votes_q;
    se_votes_d   = se_votes_q;
    nosig_d      = nosig_q;
    last_corr_d  = last_corr_q;

    if ((state_q == S_IDLE) && (state_d == S_CLEAR)) begin
      trial_idx_d  = '0;
      diff_votes_d = '0;
      se_votes_d   = '0;
      nosig_d      = '0;
    end
    if (state_q == S_CLEAR) settle_cnt_d = SET_LOAD;
    if (state_q == S_SETTLE) begin
      if (settle_cnt_q != '0) settle_cnt_d = settle_cnt_q - 1'b1;
      else                    tmo_cnt_d    = TMO_LOAD;
    end
    if ((state_q == S_MEASURE) && (tmo_cnt_q != '0)) tmo_cnt_d = tmo_cnt_q - 1'b1;
    if ((state_q == S_SAMPLE) && (state_d == S_SAMPLE)) sample_ph_d = 1'b1;

    // An abort landing on the trial-end cycle discards that trial's vote.
    if (trial_end && (state_d != S_IDLE)) begin
      diff_votes_d = diff_new;
      se_votes_d   = se_new;
      nosig_d      = nosig_new;
      if (sample_fire) last_corr_d = calc_correlation;
      if (state_d == S_CLEAR) trial_idx_d = trial_idx_q + 3'd1;
    end
  end

  always_comb begin
    calc_enable_d = (state_d == S_MEASURE);
    calc_clear_d  = (state_d == S_CLEAR);
    busy_d        = (state_d == S_CLEAR) || (state_d == S_SETTLE) || (state_d == S_MEASURE) ||
                    (state_d == S_SAMPLE) || (state_d == S_DECIDE);
    done_d        = (state_d == S_DONE);
    result_d      = result_q;
    if ((state_q == S_DECIDE) && (state_d == S_DONE)) begin
      if (majority(diff_votes_q))    result_d = 2'd2;
      else if (majority(se_votes_q)) result_d = 2'd1;
      else if (majority(nosig_q))    result_d = 2'd0;
      else                           result_d = 2'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      settle_cnt_q  <= '0;
      tmo_cnt_q     <= '0;
      sample_ph_q   <= 1'b0;
      trial_idx_q   <= '0;
      diff_votes_q  <= '0;
      se_votes_q    <= '0;
      nosig_q       <= '0;
      last_corr_q   <= '0;
      result_q      <= '0;
      calc_enable_q <= 1'b0;
      calc_clear_q  <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      settle_cnt_q  <= settle_cnt_d;
      tmo_cnt_q     <= tmo_cnt_d;
      sample_ph_q   <= sample_ph_d;
      trial_idx_q   <= trial_idx_d;
      diff_votes_q  <= diff_votes_d;
      se_votes_q    <= se_votes_d;
      nosig_q       <= nosig_d;
      last_corr_q   <= last_corr_d;
      result_q      <= result_d;
      calc_enable_q <= calc_enable_d;
      calc_clear_q  <= calc_clear_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign calc_enable      = calc_enable_q;
  assign calc_clear       = calc_clear_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign result           = result_q;
  assign trial_idx        = trial_idx_q;
  assign diff_votes       = diff_votes_q;
  assign se_votes         = se_votes_q;
  assign last_correlation = last_corr_q;

endmodule

// File: tb/tb_diff_detect_sequencer.sv
// Bench for diff_detect_sequencer: a behavioural correlation_calc model feeds
// per-trial results; verdicts are checked through an expected-result queue.
`timescale 1ns/1ps
module tb_diff_detect_sequencer;

  localparam int SETTLE = 4;
  localparam int MINE   = 64;
  localparam int TMO    = 100;
  localparam int NT     = 3;

  logic        clk = 1'b0;
  logic        reset, start, abort;
  logic        calc_enable, calc_clear;
  logic [7:0]  calc_correlation, calc_quality;
  logic [15:0] calc_edge_count;
  logic        busy, done;
  logic [1:0]  result;
  logic [2:0]  trial_idx, diff_votes, se_votes;
  logic [7:0]  last_correlation;

  always #5 clk = ~clk;

  diff_detect_sequencer #(
    .SETTLE_CYCLES(SETTLE), .MIN_EDGES(MINE), .TIMEOUT_CYCLES(TMO), .NUM_TRIALS(NT),
    .DIFF_THRESH(200), .SE_THRESH(50), .MIN_QUALITY(128)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .calc_enable(calc_enable), .calc_clear(calc_clear),
    .calc_correlation(calc_correlation), .calc_edge_count(calc_edge_count),
    .calc_quality(calc_quality), .busy(busy), .done(done), .result(result),
    .trial_idx(trial_idx), .diff_votes(diff_votes), .se_votes(se_votes),
    .last_correlation(last_correlation)
  );

  // correlation_calc stand-in: edges ramp while enabled, trial results come from tables
  logic [7:0]  corr_tbl [0:7];
  logic [7:0]  qual_tbl [0:7];
  bit          ramp = 1'b0;
  int          clr_count = 0;
  int          clr_base = 0;
  logic [15:0] edge_q = '0;
  logic [2:0]  tidx;

  always @(posedge clk) begin
    if (calc_clear) begin
      edge_q    <= '0;
      clr_count <= clr_count + 1;
    end else if (calc_enable && ramp) begin
      edge_q <= edge_q + 16'd1;
    end
  end

  assign tidx             = 3'(clr_count - clr_base - 1);
  assign calc_correlation = corr_tbl[tidx];
  assign calc_quality     = qual_tbl[tidx];
  assign calc_edge_count  = edge_q;

  typedef struct packed {
    logic [1:0] res;
    logic [2:0] dv;
    logic [2:0] sv;
    logic [7:0] lc;
  } exp_t;

  exp_t sb_q[$];
  exp_t exp_v;

  int n_checks = 0;
  int n_fail   = 0;

  // Observations from the most recent run
  bit         r_done, r_busy0, r_busy_done, r_done_next;
  int         r_cyc, r_en_cnt, r_en_min, r_en_max, r_clr_bad, r_overlap, r_gaps;
  logic [2:0] r_tpost, r_tidx_done;
  exp_t       r_obs;

  task automatic set_tbl(input logic [7:0] c0, input logic [7:0] c1, input logic [7:0] c2,
                         input logic [7:0] q);
    for (int i = 0; i < 8; i++) begin
      corr_tbl[i] = c2;
      qual_tbl[i] = q;
    end
    corr_tbl[0] = c0;
    corr_tbl[1] = c1;
  endtask

  // Pulses start, then watches outputs each negedge until done or the budget runs out.
  task automatic run_once(input string name, input int budget, input int busy_start_at);
    int  clr_len, gap, en_len;
    bit  in_gap;
    clr_len = 0; gap = 0; en_len = 0; in_gap = 1'b0;
    r_done = 1'b0; r_cyc = -1; r_en_cnt = 0; r_en_min = 1 << 30; r_en_max = 0;
    r_clr_bad = 0; r_overlap = 0; r_gaps = 0; r_tpost = 'x; r_busy_done = 1'b1;
    r_tidx_done = 'x; r_obs = 'x;
    clr_base = clr_count;
    start = 1'b1;
    abort = 1'b0;
    for (int cyc = 0; cyc < budget; cyc++) begin
      @(negedge clk);
      if (cyc == 0) begin
        start   = 1'b0;
        r_busy0 = busy;
      end
      if (busy_start_at > 0 && cyc == busy_start_at) start = 1'b1;
      if (busy_start_at > 0 && cyc == busy_start_at + 1) begin
        start   = 1'b0;
        r_tpost = trial_idx;
      end
      if (calc_clear && calc_enable) r_overlap++;
      if (calc_clear) begin
        clr_len++;
      end else begin
        if (clr_len != 0) begin
          if (clr_len != 1) r_clr_bad++;
          clr_len = 0;
          in_gap  = 1'b1;
          gap     = 0;
        end
        if (calc_enable) begin
          if (in_gap) begin
            if (gap != SETTLE) r_clr_bad++;
            in_gap = 1'b0;
            r_gaps++;
          end
          en_len++;
        end else begin
          if (en_len != 0) begin
            r_en_cnt++;
            if (en_len < r_en_min) r_en_min = en_len;
            if (en_len > r_en_max) r_en_max = en_len;
            en_len = 0;
          end
          if (in_gap) gap++;
        end
      end
      if (done) begin
        r_done      = 1'b1;
        r_cyc       = cyc;
        r_busy_done = busy;
        r_tidx_done = trial_idx;
        r_obs       = '{res: result, dv: diff_votes, sv: se_votes, lc: last_correlation};
        break;
      end
    end
    start = 1'b0;
    @(negedge clk);
    r_done_next = done;
    $display("run %s: done=%0b cycle=%0d result=%0d diff=%0d se=%0d last_corr=%0d trials=%0d",
             name, r_done, r_cyc, r_obs.res, r_obs.dv, r_obs.sv, r_obs.lc, r_en_cnt);
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    set_tbl(8'd0, 8'd0, 8'd0, 8'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({calc_enable, calc_clear, busy, done} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got en/clr/busy/done=%b want 0000",
               {calc_enable, calc_clear, busy, done});
    end
    n_checks++;
    if ({result, trial_idx, diff_votes, se_votes} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_state: got result=%0d tidx=%0d dv=%0d sv=%0d want all 0",
               result, trial_idx, diff_votes, se_votes);
    end
    n_checks++;
    if (last_correlation !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_lastcorr: got %0d want 0", last_correlation);
    end
    $display("reset: outputs sampled after release");
  endtask

  task automatic test_differential();
    ramp = 1'b1;
    set_tbl(8'd230, 8'd230, 8'd230, 8'd255);
    sb_q.push_back('{res: 2'd2, dv: 3'd2, sv: 3'd0, lc: 8'd230});
    run_once("differential", 2000, -1);
    n_checks++;
    if (r_done !== 1'b1) begin n_fail++; $display("FAIL diff_done: got %0b want 1 (no done pulse)", r_done); end
    exp_v = sb_q.pop_front();
    n_checks++;
    if (r_obs !== exp_v) begin
      n_fail++;
      $display("FAIL diff_verdict: got res=%0d dv=%0d sv=%0d lc=%0d want res=%0d dv=%0d sv=%0d lc=%0d",
               r_obs.res, r_obs.dv, r_obs.sv, r_obs.lc, exp_v.res, exp_v.dv, exp_v.sv, exp_v.lc);
    end
    n_checks++;
    if (r_busy0 !== 1'b1) begin n_fail++; $display("FAIL diff_busy_after_start: got %0b want 1", r_busy0); end
    n_checks++;
    if (r_busy_done !== 1'b0) begin n_fail++; $display("FAIL diff_busy_at_done: got %0b want 0", r_busy_done); end
    n_checks++;
    if (r_done_next !== 1'b0) begin n_fail++; $display("FAIL diff_done_width: done still %0b a cycle later, want 0", r_done_next); end
    // Two early-exit trials of clear + settle + (MIN_EDGES+1) measure + 2 sample, then decide
    n_checks++;
    if (r_cyc !== 2 * (1 + SETTLE + MINE + 1 + 2) + 1) begin
      n_fail++;
      $display("FAIL diff_latency: got cycle %0d want %0d", r_cyc, 2 * (1 + SETTLE + MINE + 1 + 2) + 1);
    end
    n_checks++;
    if (r_en_cnt !== 2 || r_en_min !== MINE + 1 || r_en_max !== MINE + 1) begin
      n_fail++;
      $display("FAIL diff_enable_runs: got %0d runs len %0d..%0d want 2 runs len %0d",
               r_en_cnt, r_en_min, r_en_max, MINE + 1);
    end
  endtask

  task automatic test_single_ended();
    ramp = 1'b1;
    set_tbl(8'd20, 8'd20, 8'd20, 8'd255);
    sb_q.push_back('{res: 2'd1, dv: 3'd0, sv: 3'd2, lc: 8'd20});
    run_once("single_ended", 2000, -1);
    n_checks++;
    if (r_done !== 1'b1) begin n_fail++; $display("FAIL se_done: got %0b want 1 (no done pulse)", r_done); end
    exp_v = sb_q.pop_front();
    n_checks++;
    if (r_obs !== exp_v) begin
      n_fail++;
      $display("FAIL se_verdict: got res=%0d dv=%0d sv=%0d lc=%0d want res=%0d dv=%0d sv=%0d lc=%0d",
               r_obs.res, r_obs.dv, r_obs.sv, r_obs.lc, exp_v.res, exp_v.dv, exp_v.sv, exp_v.lc);
    end
    n_checks++;
    if (r_en_cnt !== 2) begin n_fail++; $display("FAIL se_trials: got %0d trials want 2", r_en_cnt); end
  endtask

  task automatic test_no_signal();
    ramp = 1'b0;
    set_tbl(8'd99, 8'd99, 8'd99, 8'd255);
    // Two timeouts already form a majority of three; last_correlation keeps the previous run's 20
    sb_q.push_back('{res: 2'd0, dv: 3'd0, sv: 3'd0, lc: 8'd20});
    run_once("no_signal", 2000, -1);
    n_checks++;
    if (r_done !== 1'b1) begin n_fail++; $display("FAIL nosig_done: got %0b want 1 (no done pulse)", r_done); end
    exp_v = sb_q.pop_front();
    n_checks++;
    if (r_obs !== exp_v) begin
      n_fail++;
      $display("FAIL nosig_verdict: got res=%0d dv=%0d sv=%0d lc=%0d want res=%0d dv=%0d sv=%0d lc=%0d",
               r_obs.res, r_obs.dv, r_obs.sv, r_obs.lc, exp_v.res, exp_v.dv, exp_v.sv, exp_v.lc);
    end
    n_checks++;
    if (r_en_cnt !== 2 || r_en_min !== TMO || r_en_max !== TMO) begin
      n_fail++;
      $display("FAIL nosig_enable_runs: got %0d runs len %0d..%0d want 2 runs len %0d",
               r_en_cnt, r_en_min, r_en_max, TMO);
    end
    n_checks++;
    if (r_cyc !== 2 * (1 + SETTLE + TMO) + 1) begin
      n_fail++;
      $display("FAIL nosig_latency: got cycle %0d want %0d", r_cyc, 2 * (1 + SETTLE + TMO) + 1);
    end
  endtask

  task automatic test_mixed();
    ramp = 1'b1;
    set_tbl(8'd230, 8'd20, 8'd120, 8'd255);
    sb_q.push_back('{res: 2'd3, dv: 3'd1, sv: 3'd1, lc: 8'd120});
    run_once("mixed", 2000, -1);
    n_checks++;
    if (r_done !== 1'b1) begin n_fail++; $display("FAIL mixed_done: got %0b want 1 (no done pulse)", r_done); end
    exp_v = sb_q.pop_front();
    n_checks++;
    if (r_obs !== exp_v) begin
      n_fail++;
      $display("FAIL mixed_verdict: got res=%0d dv=%0d sv=%0d lc=%0d want res=%0d dv=%0d sv=%0d lc=%0d",
               r_obs.res, r_obs.dv, r_obs.sv, r_obs.lc, exp_v.res, exp_v.dv, exp_v.sv, exp_v.lc);
    end
    n_checks++;
    if (r_en_cnt !== 3 || r_tidx_done !== 3'd2) begin
      n_fail++;
      $display("FAIL mixed_trials: got %0d trials, trial_idx=%0d want 3 trials, trial_idx=2",
               r_en_cnt, r_tidx_done);
    end
  endtask

  task automatic test_unusable();
    ramp = 1'b1;
    set_tbl(8'd230, 8'd230, 8'd230, 8'd64);
    sb_q.push_back('{res: 2'd3, dv: 3'd0, sv: 3'd0, lc: 8'd230});
    run_once("unusable", 2000, -1);
    n_checks++;
    if (r_done !== 1'b1) begin n_fail++; $display("FAIL unusable_done: got %0b want 1 (no done pulse)", r_done); end
    exp_v = sb_q.pop_front();
    n_checks++;
    if (r_obs !== exp_v) begin
      n_fail++;
      $display("FAIL unusable_verdict: got res=%0d dv=%0d sv=%0d lc=%0d want res=%0d dv=%0d sv=%0d lc=%0d",
               r_obs.res, r_obs.dv, r_obs.sv, r_obs.lc, exp_v.res, exp_v.dv, exp_v.sv, exp_v.lc);
    end
    n_checks++;
    if (r_en_cnt !== 3) begin n_fail++; $display("FAIL unusable_trials: got %0d trials want 3", r_en_cnt); end
  endtask

  task automatic test_clear_protocol();
    ramp = 1'b1;
    set_tbl(8'd230, 8'd230, 8'd230, 8'd255);
    sb_q.push_back('{res: 2'd2, dv: 3'd2, sv: 3'd0, lc: 8'd230});
    run_once("clear_protocol", 2000, 30);
    n_checks++;
    if (r_done !== 1'b1) begin n_fail++; $display("FAIL clr_done: got %0b want 1 (no done pulse)", r_done); end
    exp_v = sb_q.pop_front();
    n_checks++;
    if (r_obs !== exp_v) begin
      n_fail++;
      $display("FAIL clr_verdict: got res=%0d dv=%0d sv=%0d lc=%0d want res=%0d dv=%0d sv=%0d lc=%0d",
               r_obs.res, r_obs.dv, r_obs.sv, r_obs.lc, exp_v.res, exp_v.dv, exp_v.sv, exp_v.lc);
    end
    n_checks++;
    if (r_clr_bad !== 0 || r_gaps !== 2) begin
      n_fail++;
      $display("FAIL clr_sequence: got %0d bad clear/settle windows over %0d trials want 0 over 2",
               r_clr_bad, r_gaps);
    end
    n_checks++;
    if (r_overlap !== 0) begin n_fail++; $display("FAIL clr_overlap: clear and enable high together %0d cycles want 0", r_overlap); end
    n_checks++;
    if (r_tpost !== 3'd0) begin n_fail++; $display("FAIL busy_start_tidx: got trial_idx=%0d after start while busy want 0", r_tpost); end
    n_checks++;
    if (r_cyc !== 2 * (1 + SETTLE + MINE + 1 + 2) + 1) begin
      n_fail++;
      $display("FAIL busy_start_latency: got cycle %0d want %0d", r_cyc, 2 * (1 + SETTLE + MINE + 1 + 2) + 1);
    end
  endtask

  task automatic test_abort();
    int  en_seen;
    bit  reached;
    ramp = 1'b1;
    set_tbl(8'd230, 8'd230, 8'd230, 8'd255);
    clr_base = clr_count;
    en_seen  = 0;
    reached  = 1'b0;
    start    = 1'b1;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (trial_idx == 3'd1 && calc_enable) en_seen++;
      if (en_seen == 10) begin
        reached = 1'b1;
        break;
      end
    end
    n_checks++;
    if (reached !== 1'b1) begin n_fail++; $display("FAIL abort_reach: got %0d measure cycles in trial 1 want 10", en_seen); end
    abort = 1'b1;
    start = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    start = 1'b0;
    n_checks++;
    if ({busy, calc_enable, calc_clear, done} !== 4'b0) begin
      n_fail++;
      $display("FAIL abort_outputs: got busy/en/clr/done=%b want 0000", {busy, calc_enable, calc_clear, done});
    end
    n_checks++;
    if (result !== 2'd2) begin n_fail++; $display("FAIL abort_result: got %0d want 2 (prior result)", result); end
    $display("abort: issued with start after %0d measure cycles of trial 1", en_seen);
    sb_q.push_back('{res: 2'd2, dv: 3'd2, sv: 3'd0, lc: 8'd230});
    run_once("after_abort", 2000, -1);
    n_checks++;
    if (r_busy0 !== 1'b1 || r_done !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_restart: got busy=%0b done=%0b want busy=1 done=1", r_busy0, r_done);
    end
    exp_v = sb_q.pop_front();
    n_checks++;
    if (r_obs !== exp_v) begin
      n_fail++;
      $display("FAIL abort_restart_verdict: got res=%0d dv=%0d sv=%0d lc=%0d want res=%0d dv=%0d sv=%0d lc=%0d",
               r_obs.res, r_obs.dv, r_obs.sv, r_obs.lc, exp_v.res, exp_v.dv, exp_v.sv, exp_v.lc);
    end
  endtask

  initial begin
    test_reset();
    test_differential();
    test_single_ended();
    test_no_signal();
    test_mixed();
    test_unusable();
    test_clear_protocol();
    test_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got no end of test want end of test");
    $fatal(1, "time limit reached");
  end

endmodule
